// File: rtl/pipe_hazard_ctl_if.sv
// pipe_hazard_ctl_if: decode-side hazard/forwarding signals between the pipeline and the hazard controller
interface pipe_hazard_ctl_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(NREG);
  logic de_valid;
  logic [AW-1:0] de_rs1;
  logic [AW-1:0] de_rs2;
  logic de_use_rs1;
  logic de_use_rs2;
  logic [AW-1:0] de_rd;
  logic de_regwen;
  logic de_is_load;
  logic [XLEN-1:0] rf_data_a;
  logic [XLEN-1:0] rf_data_b;
  logic [XLEN-1:0] exe_fwd_data;
  logic [XLEN-1:0] acc_fwd_data;
  logic [XLEN-1:0] wb_fwd_data;
  logic branch_taken;
  logic [XLEN-1:0] data_a_fwd;
  logic [XLEN-1:0] data_b_fwd;
  logic stall;
  logic flush_de;
  logic flush_exe;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master(
    output de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd, de_regwen, de_is_load,
    output rf_data_a, rf_data_b, exe_fwd_data, acc_fwd_data, wb_fwd_data, branch_taken,
    input data_a_fwd, data_b_fwd, stall, flush_de, flush_exe, stall_cnt, flush_cnt
  );
  modport slave(
    input de_valid, de_rs1, de_rs2, de_use_rs1, de_use_rs2, de_rd, de_regwen, de_is_load,
    input rf_data_a, rf_data_b, exe_fwd_data, acc_fwd_data, wb_fwd_data, branch_taken,
    output data_a_fwd, data_b_fwd, stall, flush_de, flush_exe, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctl.sv
// pipe_hazard_ctl: scoreboard-based load-use/RAW stall, branch flush and operand forwarding (HAZ_FWD_EN enables forwarding)
module pipe_hazard_ctl #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic rst,
  pipe_hazard_ctl_if.slave bus
);
  localparam int AW = $clog2(NREG);
  typedef struct packed {
    logic valid;
    logic [AW-1:0] rd;
    logic regwen;
    logic is_load;
  } slot_t;
  slot_t exe_s, acc_s, wb_s;
  logic [2:0] hit_a, hit_b;
  logic hazard;
  logic unused;
  assign unused = wb_s.is_load;
  function automatic logic hit(slot_t s, logic [AW-1:0] rs, logic use_rs);
    return s.valid && s.regwen && s.rd != '0 && s.rd == rs && use_rs;
  endfunction
  // source matches against each slot, operand selection and hazard outputs
  always_comb begin
    hit_a = {hit(wb_s, bus.de_rs1, bus.de_use_rs1), hit(acc_s, bus.de_rs1, bus.de_use_rs1), hit(exe_s, bus.de_rs1, bus.de_use_rs1)};
    hit_b = {hit(wb_s, bus.de_rs2, bus.de_use_rs2), hit(acc_s, bus.de_rs2, bus.de_use_rs2), hit(exe_s, bus.de_rs2, bus.de_use_rs2)};
`ifdef HAZ_FWD_EN
    bus.data_a_fwd = hit_a[0] ? bus.exe_fwd_data : hit_a[1] ? bus.acc_fwd_data : hit_a[2] ? bus.wb_fwd_data : bus.rf_data_a;
    bus.data_b_fwd = hit_b[0] ? bus.exe_fwd_data : hit_b[1] ? bus.acc_fwd_data : hit_b[2] ? bus.wb_fwd_data : bus.rf_data_b;
    hazard = (hit_a[0] | hit_b[0]) & exe_s.is_load;
`else
    bus.data_a_fwd = bus.rf_data_a;
    bus.data_b_fwd = bus.rf_data_b;
    hazard = |{hit_a, hit_b};
`endif
    bus.stall = bus.de_valid & hazard & ~bus.branch_taken;
    bus.flush_de = bus.branch_taken;
    bus.flush_exe = bus.stall | bus.branch_taken;
  end
  // scoreboard shift chain and saturating event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      exe_s <= '0;
      acc_s <= '0;
      wb_s <= '0;
      bus.stall_cnt <= '0;
      bus.flush_cnt <= '0;
    end else begin
      wb_s <= acc_s;
      acc_s <= exe_s;
      exe_s <= (bus.de_valid && !bus.stall && !bus.branch_taken) ? {1'b1, bus.de_rd, bus.de_regwen, bus.de_is_load} : '0;
      bus.stall_cnt <= (bus.stall && !(&bus.stall_cnt)) ? bus.stall_cnt + 1'b1 : bus.stall_cnt;
      bus.flush_cnt <= (bus.branch_taken && !(&bus.flush_cnt)) ? bus.flush_cnt + 1'b1 : bus.flush_cnt;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// tb_pipe_hazard_ctl: directed and randomized checks of pipe_hazard_ctl against an instruction-history model
module tb_pipe_hazard_ctl;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int CNT_W = 4;
  localparam int CMAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  pipe_hazard_ctl_if #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) bus();
  pipe_hazard_ctl #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut(.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    bit v;
    int rd;
    bit wen;
    bit ld;
  } ins_t;
  ins_t hist[$];
  ins_t bub = '{0, 0, 0, 0};
  int m_stall_cnt, m_flush_cnt;
  int tests = 0;
  int errs = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit dep(input ins_t p, input int rs, input bit u);
    return p.v && p.wen && p.rd != 0 && p.rd == rs && u;
  endfunction
  function automatic logic [31:0] fwd(input int rs, input bit u, input logic [31:0] rf);
`ifdef HAZ_FWD_EN
    if (dep(hist[0], rs, u)) return bus.exe_fwd_data;
    if (dep(hist[1], rs, u)) return bus.acc_fwd_data;
    if (dep(hist[2], rs, u)) return bus.wb_fwd_data;
`endif
    return rf;
  endfunction
  task automatic cyc();
    bit haz, st, br;
    #1;
    br = bus.branch_taken;
    haz = 0;
    for (int i = 0; i < 3; i++) begin
      bit d;
      d = dep(hist[i], int'(bus.de_rs1), bus.de_use_rs1) || dep(hist[i], int'(bus.de_rs2), bus.de_use_rs2);
`ifdef HAZ_FWD_EN
      if (i == 0 && d && hist[0].ld) haz = 1;
`else
      if (d) haz = 1;
`endif
    end
    st = bus.de_valid && haz && !br;
    chk("data_a_fwd", bus.data_a_fwd, fwd(int'(bus.de_rs1), bus.de_use_rs1, bus.rf_data_a));
    chk("data_b_fwd", bus.data_b_fwd, fwd(int'(bus.de_rs2), bus.de_use_rs2, bus.rf_data_b));
    chk("stall", 32'(bus.stall), 32'(st));
    chk("flush_de", 32'(bus.flush_de), 32'(br));
    chk("flush_exe", 32'(bus.flush_exe), 32'(st || br));
    chk("stall_cnt", 32'(bus.stall_cnt), m_stall_cnt);
    chk("flush_cnt", 32'(bus.flush_cnt), m_flush_cnt);
    @(posedge clk);
    if (rst) begin
      hist = '{bub, bub, bub};
      m_stall_cnt = 0;
      m_flush_cnt = 0;
    end else begin
      hist.push_front('{bus.de_valid && !st && !br, int'(bus.de_rd), bus.de_regwen, bus.de_is_load});
      void'(hist.pop_back());
      if (st && m_stall_cnt < CMAX) m_stall_cnt++;
      if (br && m_flush_cnt < CMAX) m_flush_cnt++;
    end
    @(negedge clk);
  endtask
  task automatic set_de(input bit v, input int rs1, input bit u1, input int rs2, input bit u2, input int rd, input bit wen, input bit ld);
    bus.de_valid = v;
    bus.de_rs1 = 5'(rs1);
    bus.de_use_rs1 = u1;
    bus.de_rs2 = 5'(rs2);
    bus.de_use_rs2 = u2;
    bus.de_rd = 5'(rd);
    bus.de_regwen = wen;
    bus.de_is_load = ld;
  endtask
  task automatic idle();
    set_de(0, 0, 0, 0, 0, 0, 0, 0);
    bus.branch_taken = 0;
    bus.rf_data_a = 32'h11;
    bus.rf_data_b = 32'h22;
    bus.exe_fwd_data = 32'h33;
    bus.acc_fwd_data = 32'h44;
    bus.wb_fwd_data = 32'h55;
  endtask
  task automatic rst_cycle();
    idle();
    rst = 1;
    cyc();
    rst = 0;
  endtask
  initial begin
    idle();
    hist = '{bub, bub, bub};
    m_stall_cnt = 0;
    m_flush_cnt = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    chk("reset data_a", bus.data_a_fwd, 32'h11);
    chk("reset stall", 32'(bus.stall), 0);
    chk("reset stall_cnt", 32'(bus.stall_cnt), 0);
    chk("reset flush_cnt", 32'(bus.flush_cnt), 0);
    cyc();
`ifdef HAZ_FWD_EN
    set_de(1, 0, 0, 0, 0, 5, 1, 0);
    cyc();
    set_de(1, 5, 1, 0, 0, 0, 0, 0);
    bus.exe_fwd_data = 32'hDEAD;
    #1;
    chk("fwd exe", bus.data_a_fwd, 32'hDEAD);
    chk("fwd exe stall", 32'(bus.stall), 0);
    cyc();
    bus.acc_fwd_data = 32'hBEEF;
    #1;
    chk("fwd acc", bus.data_a_fwd, 32'hBEEF);
    cyc();
`else
    rst_cycle();
    set_de(1, 0, 0, 0, 0, 3, 1, 0);
    cyc();
    set_de(1, 3, 1, 0, 0, 0, 0, 0);
    bus.exe_fwd_data = 32'hAAAA;
    bus.rf_data_a = 32'h5A5A;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("raw stall", 32'(bus.stall), 1);
      chk("raw data_a", bus.data_a_fwd, 32'h5A5A);
      cyc();
    end
    #1;
    chk("raw stall end", 32'(bus.stall), 0);
    chk("raw stall_cnt", 32'(bus.stall_cnt), 3);
    cyc();
`endif
    rst_cycle();
    set_de(1, 0, 0, 0, 0, 7, 1, 1);
    cyc();
    set_de(1, 0, 0, 7, 1, 0, 0, 0);
    #1;
    chk("ld-use stall", 32'(bus.stall), 1);
    chk("ld-use flush_exe", 32'(bus.flush_exe), 1);
    cyc();
    bus.acc_fwd_data = 32'h1234;
    #1;
    chk("ld-use stall_cnt", 32'(bus.stall_cnt), 1);
`ifdef HAZ_FWD_EN
    chk("ld-use fwd b", bus.data_b_fwd, 32'h1234);
    chk("ld-use stall end", 32'(bus.stall), 0);
`endif
    cyc();
    rst_cycle();
    set_de(1, 0, 0, 0, 0, 0, 1, 0);
    cyc();
    set_de(1, 0, 1, 0, 0, 0, 0, 0);
    bus.rf_data_a = 32'h0;
    bus.exe_fwd_data = 32'hDEAD;
    #1;
    chk("x0 data_a", bus.data_a_fwd, 32'h0);
    chk("x0 stall", 32'(bus.stall), 0);
    cyc();
    rst_cycle();
    set_de(1, 0, 0, 0, 0, 7, 1, 1);
    cyc();
    set_de(1, 0, 0, 7, 1, 0, 0, 0);
    bus.branch_taken = 1;
    #1;
    chk("br flush_de", 32'(bus.flush_de), 1);
    chk("br flush_exe", 32'(bus.flush_exe), 1);
    chk("br stall", 32'(bus.stall), 0);
    cyc();
    idle();
    #1;
    chk("br flush_cnt", 32'(bus.flush_cnt), 1);
    chk("br stall_cnt", 32'(bus.stall_cnt), 0);
    cyc();
    rst_cycle();
    bus.branch_taken = 1;
    for (int k = 0; k < 20; k++) cyc();
    idle();
    #1;
    chk("flush_cnt sat", 32'(bus.flush_cnt), CMAX);
    for (int k = 0; k < 18; k++) begin
      set_de(1, 0, 0, 0, 0, 7, 1, 1);
      cyc();
      set_de(1, 0, 0, 7, 1, 0, 0, 0);
      cyc();
      idle();
      cyc();
    end
    #1;
    chk("stall_cnt sat", 32'(bus.stall_cnt), CMAX);
    rst_cycle();
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      set_de($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1));
      bus.branch_taken = ($urandom_range(0, 7) == 0);
      bus.rf_data_a = $urandom;
      bus.rf_data_b = $urandom;
      bus.exe_fwd_data = $urandom;
      bus.acc_fwd_data = $urandom;
      bus.wb_fwd_data = $urandom;
      cyc();
    end
    rst = 0;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule
